// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the 4-bit CPU boot path.
package cpu_pkg;

  localparam int WIDTH  = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Load stream and instruction fetch bus between the loader and its neighbours.
interface prog_loader_if;
  import cpu_pkg::*;

  logic              start;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;

  modport master (
    output start, in_valid, in_data, rd_addr,
    input  in_ready, rd_data
  );

  modport slave (
    input  start, in_valid, in_data, rd_addr,
    output in_ready, rd_data
  );

endinterface

// File: rtl/prog_loader_mem.sv
// Instruction store: one synchronous write port, one combinational read port,
// asynchronously cleared so the CPU never fetches stale code after reset.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int P_DEPTH  = DEPTH,
  parameter int P_WIDTH  = WIDTH,
  parameter int P_ADDR_W = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [P_ADDR_W-1:0] waddr_i,
  input  logic [P_WIDTH-1:0]  wdata_i,
  input  logic [P_ADDR_W-1:0] raddr_i,
  output logic [P_WIDTH-1:0]  rdata_o
);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Boot sequencer: holds the CPU in reset while a program streams in, then
// releases it. Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR word.
module prog_loader
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus,
  output logic         cpu_rstn,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LOAD  = LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = CHECK;
`endif
  localparam logic [2:0] ST_RUN   = RUN;
  localparam logic [2:0] ST_ERROR = ERROR;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mem_we;
  logic              xfer;
  logic              accepting;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]  xor_q, xor_d;
`endif

  // in_ready is a pure decode of the state register, never of in_valid.
`ifdef PROG_LOADER_CHECKSUM_EN
  assign accepting = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign accepting = (state_q == ST_LOAD);
`endif

  assign bus.in_ready = accepting;
  assign xfer         = bus.in_valid && accepting;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d = '0;
`endif
        if (bus.start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + ADDR_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ bus.in_data;
          if (cnt_q == LAST_ADDR) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_ADDR) state_d = ST_RUN;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        // The checksum word is compared only, never written to the store.
        if (xfer) state_d = (bus.in_data == xor_q) ? ST_RUN : ST_ERROR;
      end
`endif
      ST_RUN, ST_ERROR: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  prog_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (cnt_q),
    .wdata_i (bus.in_data),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign busy     = accepting;
  assign done     = (state_q == ST_RUN);
  assign cpu_rstn = (state_q == ST_RUN);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err      = (state_q == ST_ERROR);
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader with a word-count/array reference model.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int NW = 9;
`else
  localparam int NW = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cpu_rstn, busy, done, err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program contents, words received, and outcome flags.
  logic [3:0] m_mem [8];
  logic [3:0] m_x;
  int         m_n;
  bit         m_load, m_run, m_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    m_x = 4'h0; m_n = 0; m_load = 0; m_run = 0; m_fail = 0;
  endtask

  task automatic model_step(input bit st, input bit v, input logic [3:0] d);
    if (m_load) begin
      if (v) begin
        if (m_n < 8) begin
          m_mem[m_n] = d;
          m_x = m_x ^ d;
          m_n++;
`ifndef PROG_LOADER_CHECKSUM_EN
          if (m_n == 8) begin m_load = 0; m_run = 1; end
`endif
        end else begin
          m_load = 0;
          if (d == m_x) m_run = 1; else m_fail = 1;
        end
      end
    end else if (st) begin
      m_load = 1; m_run = 0; m_fail = 0; m_n = 0; m_x = 4'h0;
    end
  endtask

  task automatic step(input bit st, input bit v, input logic [3:0] d);
    @(negedge clk);
    #1;
    bus.start    = st;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_addr  = 3'($urandom_range(0, 7));
    @(posedge clk);
    model_step(st, v, d);
  endtask

  task automatic check_all_reset(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cpu_rstn"}, cpu_rstn, 0);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #0.1;
      chk({tag, "_rd_zero"}, bus.rd_data, 0);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, m_load);
    chk("busy", busy, m_load);
    chk("done", done, m_run);
    chk("err", err, m_fail);
    chk("cpu_rstn", cpu_rstn, m_run);
    chk("rd_data", bus.rd_data, m_mem[bus.rd_addr]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] words [8];
    logic [3:0] x;
    int         got;
    bit         v;

    rst = 1'b1;
    bus.start = 0; bus.in_valid = 0; bus.in_data = 0; bus.rd_addr = 0;
    model_reset();
    #1;
    check_all_reset("por");
    @(negedge clk); #1 rst = 1'b0;

    repeat (3) step(0, 0, 4'h0);

    // Clean load of 1..8, checksum 8.
    step(1, 0, 4'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i + 1));
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("clean_done_before_ck", done, 0);
    step(0, 1, 4'h8);
`endif
    #1;
    chk("clean_done", done, 1);
    chk("clean_cpu_rstn", cpu_rstn, 1);
    chk("model_mem2", m_mem[2], 4'h3);
    bus.rd_addr = 3'd2; #1 chk("clean_rd2", bus.rd_data, 4'h3);
    bus.rd_addr = 3'd7; #1 chk("clean_rd7", bus.rd_data, 4'h8);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum.
    step(1, 0, 4'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i + 1));
    step(0, 1, 4'h0);
    #1;
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_rstn", cpu_rstn, 0);
    chk("bad_in_ready", bus.in_ready, 0);
`endif

    // Stalled handshake: in_valid toggles every cycle.
    step(1, 0, 4'h0);
    got = 0; x = 4'h0;
    for (int i = 0; i < 8; i++) words[i] = 4'($urandom_range(0, 15));
    for (int c = 0; c < 40 && got < NW; c++) begin
      v = (c % 2 == 1);
      step(0, v, (got < 8) ? words[got] : x);
      if (v) begin
        if (got < 8) x = x ^ words[got];
        got++;
      end
    end
    chk("stall_xfers", got, NW);
    #1 chk("stall_done", done, 1);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #0.1 chk("stall_contents", bus.rd_data, words[a]);
    end
    step(0, 1, 4'hA);
    step(0, 1, 4'h5);

    // Reload from RUN with all-F program.
    step(1, 0, 4'h0);
    #1 chk("reload_cpu_rstn", cpu_rstn, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'hF);
`ifdef PROG_LOADER_CHECKSUM_EN
    step(0, 1, 4'h0);
`endif
    #1 chk("reload_done", done, 1);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #0.1 chk("reload_rdF", bus.rd_data, 4'hF);
    end

    // Random loads with random stalls, stray starts and checksums.
    for (int r = 0; r < 8; r++) begin
      step(1, 0, 4'h0);
      got = 0; x = 4'h0;
      for (int c = 0; c < 100 && got < NW; c++) begin
        logic [3:0] d;
        v = ($urandom_range(0, 2) != 0);
        d = 4'($urandom_range(0, 15));
        if (got == 8 && $urandom_range(0, 1) == 1) d = x;
        step(($urandom_range(0, 7) == 0), v, d);
        if (v) begin
          if (got < 8) x = x ^ d;
          got++;
        end
      end
      chk("rand_xfers", got, NW);
      repeat ($urandom_range(1, 4)) step(0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    // Abort mid-load with an asynchronous reset.
    step(1, 0, 4'h0);
    step(0, 1, 4'h9);
    step(0, 1, 4'hA);
    step(0, 1, 4'hB);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_reset("abort");
    @(negedge clk); #1 rst = 1'b0;
    step(1, 0, 4'h0);
    step(0, 1, 4'h5);
    #1;
    bus.rd_addr = 3'd0; #1 chk("abort_rd0", bus.rd_data, 4'h5);
    bus.rd_addr = 3'd1; #1 chk("abort_rd1", bus.rd_data, 4'h0);
    step(0, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Programmable instruction store and boot sequencer for the 4-bit CPU. It sits directly upstream of the CPU's instruction fetch and replaces its fixed ROM with an 8-entry × 4-bit writable array. While a program is loaded over a valid/ready byte stream, the CPU is held in reset. Once all words are written, and the checksum passes if that feature is compiled in, the CPU is released. After release, the CPU's program counter indexes the array combinationally.

## Interface
- `DEPTH`, 8: number of instruction words; must be a power of two.
- `WIDTH`, 4: instruction word width.
- `ADDR_W`, 3: address width, equal to log2(`DEPTH`).
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high; clears all state immediately.
- `start`  input  1  single-cycle request to begin a load.
- `in_valid`  input  1  a load word is present on `in_data`.
- `in_data`  input  `WIDTH`  load word.
- `in_ready`  output  1  loader accepts a word this cycle.
- `rd_addr`  input  `ADDR_W`  fetch address; connects to the CPU `pc_out`.
- `rd_data`  output  `WIDTH`  fetched instruction; connects to the CPU instruction input.
- `cpu_rstn`  output  1  active-low reset driven to the CPU.
- `busy`  output  1  a load is in progress.
- `done`  output  1  the program was loaded successfully and the CPU is running.
- `err`  output  1  checksum mismatch; the CPU is held in reset.

## Operation
- States:
  - `IDLE`: no program loaded.
  - `LOAD`: accepting program words.
  - `CHECK`: accepting the checksum word (checksum builds only).
  - `RUN`: program loaded, CPU released.
  - `ERROR`: checksum failed.
- Reset state is `IDLE`.
- A transfer occurs on a rising edge where `in_valid && in_ready` is true.
- `IDLE`:
  - `start` → `LOAD`.
  - Word counter cleared to 0, running XOR cleared to 0.
- `LOAD`:
  - `in_ready`=1.
  - Each transfer writes `mem[cnt] <= in_data`, sets `xor <= xor ^ in_data`, then increments `cnt`.
  - The transfer at `cnt`=`DEPTH`-1 goes to `CHECK` when the checksum is enabled, otherwise to `RUN`.
  - `cnt` wraps to 0 at that point.
- `CHECK`:
  - `in_ready`=1.
  - One transfer is compared against `xor`: equal → `RUN`; unequal → `ERROR`.
  - The checksum word is not stored.
- `RUN`: `done`=1, `cpu_rstn`=1.
- `ERROR`: `err`=1, `cpu_rstn`=0.
- From `RUN` or `ERROR`, `start` → `LOAD` and clears `cnt` and `xor`. `cpu_rstn` returns to 0 in the same cycle the state enters `LOAD`.
- `start` is ignored in `LOAD` and `CHECK`.
- `busy` is 1 exactly in `LOAD` and `CHECK`.
- `in_ready` is a registered decode of the state. It does not depend on `in_valid`.
- Read path:
  - `rd_data = mem[rd_addr]`, combinational, in every state.
  - During a load it returns whatever contents are present at that moment.
- Memory contents are reset to all zeros by `rst`. They are otherwise retained across `ERROR` and across reloads until overwritten.
- Words beyond the program plus checksum are not accepted, because `in_ready`=0 outside `LOAD` and `CHECK`.

## Timing
- Reset values:
  - `in_ready`=0, `cpu_rstn`=0, `busy`=0, `done`=0, `err`=0.
  - `rd_data`=0 for any `rd_addr`.
  - State `IDLE`, `cnt`=0, `xor`=0.
- `start` sampled at edge N → `busy`=1 and `in_ready`=1 from N+1.
- The first word can transfer at edge N+1.
- A word written at edge M is visible on `rd_data` after edge M.
- Load latency with back-to-back `in_valid`: `DEPTH` transfers, plus 1 checksum transfer when the checksum is enabled.
- `done` and `cpu_rstn` rise on the edge that completes the last transfer. The CPU leaves reset on the following edge.
- Mid-operation `rst` aborts immediately: all outputs return to their reset values asynchronously, with no partial-load recovery.
- `rst` deassertion is synchronised by the integrator. The block uses no internal reset synchroniser.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - `CHECK` state and the `xor` register exist.
  - `ERROR` is reachable.
  - A load is `DEPTH`+1 words.
- Undefined:
  - `CHECK` is removed and `xor` is not built.
  - `err` is tied to 0.
  - The last program word goes straight to `RUN`.
  - A load is `DEPTH` words.

## Structure
- The shared package `cpu_pkg` holds:
  - the `WIDTH` and `ADDR_W` constants;
  - the state enumeration `loader_state_t` (`IDLE`, `LOAD`, `CHECK`, `RUN`, `ERROR`).
- One natural sub-module is `prog_mem`:
  - an 8×4 register array with one synchronous write port and one combinational read port;
  - asynchronous clear on `rst`.
- The FSM, counter and checksum logic live in `prog_loader`.

## Test plan
- Reset values: assert `rst` mid-cycle → all outputs 0 immediately, and `rd_data`=0 for every `rd_addr` 0–7.
- Clean load, checksum enabled:
  - Stimulus: `start`, then words 1,2,3,4,5,6,7,8 back-to-back, then checksum 8 (the XOR of the eight words).
  - Required response: `done`=1 and `cpu_rstn`=1 on the 9th transfer edge; `rd_addr`=2 → `rd_data`=3; `rd_addr`=7 → `rd_data`=8.
- Bad checksum: same eight words, then checksum 0 → `err`=1, `done`=0, `cpu_rstn` stays 0, `in_ready`=0.
- Stalled handshake:
  - Stimulus: toggle `in_valid` every other cycle during the load.
  - Required response: exactly 8 (or 9 with checksum) transfers; contents match; `in_ready` stays 1 through the gaps.
- Reload from `RUN`:
  - Stimulus: `start` → `cpu_rstn`=0 on the next edge, then load all words as 4'hF; with the checksum enabled the checksum word is 0.
  - Required response: `rd_data`=F at every address, then `done`=1.
- Abort: `rst` after 3 words → `busy`=0 at once; after release `start` restarts at address 0 and the memory reads all zeros.
